// File: rtl/vga_mem_arbiter_if.sv
// vga_mem_arbiter_if
// Bundles the video read port, the CPU read/write port and the on-chip
// memory command/return signals that vga_mem_arbiter sits between.
//
// Ports (by modport):
//   slave  - the arbiter. It takes the client requests and mem_readdata.
//            It drives the waitrequests, the read returns and the memory command.
//   master - the surroundings: the video fetcher, the CPU master and the memory.
//            This is the mirror image of slave.
//
// Parameters:
//   ADDR_W - word address width (32768 words at 15)
//   DATA_W - data width; byteenable is DATA_W/8 lanes
interface vga_mem_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic                  freeze;

    logic [ADDR_W-1:0]     vid_address;
    logic                  vid_read;
    logic                  vid_waitrequest;
    logic [DATA_W-1:0]     vid_readdata;
    logic                  vid_readdatavalid;

    logic [ADDR_W-1:0]     cpu_address;
    logic                  cpu_read;
    logic                  cpu_write;
    logic [DATA_W/8-1:0]   cpu_byteenable;
    logic [DATA_W-1:0]     cpu_writedata;
    logic                  cpu_waitrequest;
    logic [DATA_W-1:0]     cpu_readdata;
    logic                  cpu_readdatavalid;

    logic [ADDR_W-1:0]     mem_address;
    logic [DATA_W/8-1:0]   mem_byteenable;
    logic                  mem_chipselect;
    logic                  mem_write;
    logic [DATA_W-1:0]     mem_writedata;
    logic                  mem_clken;
    logic [DATA_W-1:0]     mem_readdata;

    modport slave (
        input  freeze,
        input  vid_address, vid_read,
        output vid_waitrequest, vid_readdata, vid_readdatavalid,
        input  cpu_address, cpu_read, cpu_write, cpu_byteenable, cpu_writedata,
        output cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken,
        input  mem_readdata
    );

    modport master (
        output freeze,
        output vid_address, vid_read,
        input  vid_waitrequest, vid_readdata, vid_readdatavalid,
        output cpu_address, cpu_read, cpu_write, cpu_byteenable, cpu_writedata,
        input  cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter
// Shares one single-port 32K x 32 image memory between the video pixel
// fetcher (read-only) and the CPU master (read/write). Video has priority.
// While a CPU request is pending, video may win at most MAX_VID_RUN times
// in a row, and then the CPU is served. Grants are combinational. Read data
// comes back one cycle after the grant, with a valid strobe on the port
// that was granted.
//
// Ports:
//   clk     - system clock
//   reset_n - synchronous, active-low reset
//   bus     - vga_mem_arbiter_if.slave, which carries:
//             the video read port, the CPU read/write port and the memory drive
//
// Parameters:
//   ADDR_W      - word address width
//   DATA_W      - data width
//   MAX_VID_RUN - consecutive video grants allowed while the CPU waits (1..255)
module vga_mem_arbiter #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 32,
    parameter int MAX_VID_RUN = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    vga_mem_arbiter_if.slave      bus
);
    localparam int         BE_W      = DATA_W / 8;
    localparam logic [7:0] RUN_LIMIT = 8'(MAX_VID_RUN);

    logic [7:0]        run_cnt;
    logic              rv_vid;
    logic              rv_cpu;
    logic              cpu_req;
    logic              grant_vid;
    logic              grant_cpu;
    logic [ADDR_W-1:0] sel_address;

    // Grant decision. Video wins unless the CPU is waiting and video has
    // already used up its run. Nothing is granted in reset or freeze.
    always_comb begin
        cpu_req   = bus.cpu_read | bus.cpu_write;
        grant_vid = reset_n & ~bus.freeze & bus.vid_read
                    & (~cpu_req | (run_cnt < RUN_LIMIT));
        grant_cpu = reset_n & ~bus.freeze & cpu_req & ~grant_vid;
    end

    // The memory command follows the granted port. When nothing is granted,
    // the address parks on the video address and chipselect stays low.
    always_comb begin
        sel_address        = grant_cpu ? bus.cpu_address : bus.vid_address;
        bus.mem_address    = sel_address;
        bus.mem_chipselect = grant_vid | grant_cpu;
        bus.mem_write      = grant_cpu & bus.cpu_write;
        bus.mem_byteenable = (grant_cpu & bus.cpu_write) ? bus.cpu_byteenable
                                                         : {BE_W{1'b1}};
        bus.mem_writedata  = bus.cpu_writedata;
        bus.mem_clken      = ~bus.freeze;
    end

    assign bus.vid_waitrequest   = ~grant_vid;
    assign bus.cpu_waitrequest   = ~grant_cpu;
    assign bus.vid_readdatavalid = rv_vid;
    assign bus.cpu_readdatavalid = rv_cpu;
    assign bus.vid_readdata      = bus.mem_readdata;
    assign bus.cpu_readdata      = bus.mem_readdata;

    // Return strobes and the video run counter.
    // The strobes reload every cycle, including during freeze. The memory
    // address register is clock-gated during freeze, so a read granted just
    // before freeze still returns stable data.
    // run_cnt counts video wins while the CPU waits. Freeze leaves it unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rv_vid  <= 1'b0;
            rv_cpu  <= 1'b0;
            run_cnt <= 8'd0;
        end else begin
            rv_vid <= grant_vid & bus.vid_read;
            rv_cpu <= grant_cpu & bus.cpu_read & ~bus.cpu_write;
            if (!bus.freeze) begin
                if (grant_cpu || !cpu_req) begin
                    run_cnt <= 8'd0;
                end else if (grant_vid && (run_cnt < RUN_LIMIT)) begin
                    run_cnt <= run_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter
// Bench for vga_mem_arbiter. It includes a behavioural 32K x 32 memory that
// has a clock-enabled address register and an unregistered read port.
// A scoreboard model tracks, every cycle, which port should own the memory.
// It also holds a shadow copy of the memory contents and the read return
// expected in the next cycle.
module tb_vga_mem_arbiter;
    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 32;
    localparam int MAX_RUN = 8;
    localparam int DEPTH   = 32768;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    vga_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vga_mem_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MAX_VID_RUN (MAX_RUN)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [31:0] initWord(input int idx);
        return (32'(idx) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    // On-chip memory stand-in. The first edge preloads a known pattern.
    // After that the memory samples its address and performs any write when
    // clken is high, and its output always reflects the registered address.
    logic [31:0]       ram [0:DEPTH-1];
    logic [14:0]       ram_addr_q = '0;
    logic              ram_ready  = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= initWord(i);
            ram_ready <= 1'b1;
        end else if (bus.mem_clken) begin
            ram_addr_q <= bus.mem_address;
            if (bus.mem_chipselect && bus.mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_byteenable[b])
                        ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
                end
            end
        end
    end

    assign bus.mem_readdata = ram[ram_addr_q];

    int checks_done   = 0;
    int checks_failed = 0;

    // Reference model state
    logic [31:0] shadow [0:DEPTH-1];
    int          vid_streak  = 0;
    logic        exp_rv_vid  = 1'b0;
    logic        exp_rv_cpu  = 1'b0;
    logic [31:0] exp_rdata   = '0;
    logic        model_gv    = 1'b0;
    logic        model_gc    = 1'b0;

    // Values observed from the DUT in the most recent cycle
    logic        obs_vgnt, obs_cgnt, obs_vvalid, obs_cvalid;
    logic        obs_cs, obs_mwrite, obs_clken;
    logic [31:0] obs_crdata;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_done++;
        if (obs !== exp) begin
            checks_failed++;
            $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compares the DUT with the model for the current cycle, then moves the
    // model forward to the upcoming clock edge.
    task automatic modelCycle();
        logic cpu_req, gv, gc;
        cpu_req = bus.cpu_read | bus.cpu_write;
        gv = reset_n && !bus.freeze && bus.vid_read && (!cpu_req || vid_streak < MAX_RUN);
        gc = reset_n && !bus.freeze && cpu_req && !gv;
        model_gv = gv;
        model_gc = gc;

        obs_vgnt   = !bus.vid_waitrequest;
        obs_cgnt   = !bus.cpu_waitrequest;
        obs_vvalid = bus.vid_readdatavalid;
        obs_cvalid = bus.cpu_readdatavalid;
        obs_cs     = bus.mem_chipselect;
        obs_mwrite = bus.mem_write;
        obs_clken  = bus.mem_clken;
        obs_crdata = bus.cpu_readdata;

        checkOutput("vid_waitrequest", bus.vid_waitrequest, !gv);
        checkOutput("cpu_waitrequest", bus.cpu_waitrequest, !gc);
        checkOutput("mem_chipselect", bus.mem_chipselect, gv | gc);
        checkOutput("mem_write", bus.mem_write, gc & bus.cpu_write);
        checkOutput("mem_clken", bus.mem_clken, !bus.freeze);
        checkOutput("mem_address", bus.mem_address, gc ? bus.cpu_address : bus.vid_address);
        checkOutput("mem_byteenable", bus.mem_byteenable,
                    (gc && bus.cpu_write) ? bus.cpu_byteenable : 4'hF);
        checkOutput("mem_writedata", bus.mem_writedata, bus.cpu_writedata);
        checkOutput("vid_readdatavalid", bus.vid_readdatavalid, exp_rv_vid);
        checkOutput("cpu_readdatavalid", bus.cpu_readdatavalid, exp_rv_cpu);
        if (exp_rv_vid) checkOutput("vid_readdata", bus.vid_readdata, exp_rdata);
        if (exp_rv_cpu) checkOutput("cpu_readdata", bus.cpu_readdata, exp_rdata);

        if (!reset_n) begin
            exp_rv_vid = 1'b0;
            exp_rv_cpu = 1'b0;
            vid_streak = 0;
        end else begin
            exp_rv_vid = gv;
            exp_rv_cpu = gc && bus.cpu_read && !bus.cpu_write;
            if (gv) exp_rdata = shadow[bus.vid_address];
            else if (exp_rv_cpu) exp_rdata = shadow[bus.cpu_address];
            if (gc && bus.cpu_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.cpu_byteenable[b])
                        shadow[bus.cpu_address][8*b +: 8] = bus.cpu_writedata[8*b +: 8];
                end
            end
            if (!bus.freeze) begin
                if (gc || !cpu_req) vid_streak = 0;
                else if (gv) vid_streak++;
            end
        end
    endtask

    // Drives one cycle of inputs, checks at the falling edge and returns
    // just after the next rising edge.
    task automatic applyStimulus(input logic rn, input logic frz,
                                 input logic vr, input logic [14:0] va,
                                 input logic cr, input logic cw, input logic [3:0] be,
                                 input logic [14:0] ca, input logic [31:0] wd);
        reset_n            = rn;
        bus.freeze         = frz;
        bus.vid_read       = vr;
        bus.vid_address    = va;
        bus.cpu_read       = cr;
        bus.cpu_write      = cw;
        bus.cpu_byteenable = be;
        bus.cpu_address    = ca;
        bus.cpu_writedata  = wd;
        @(negedge clk);
        modelCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        vr, cr, cw, frz;
        logic [14:0] va, ca;
        logic [3:0]  be;
        logic [31:0] wd;
        int          kind;

        for (int i = 0; i < DEPTH; i++) shadow[i] = initWord(i);
        reset_n            = 1'b0;
        bus.freeze         = 1'b0;
        bus.vid_read       = 1'b0;
        bus.vid_address    = '0;
        bus.cpu_read       = 1'b0;
        bus.cpu_write      = 1'b0;
        bus.cpu_byteenable = '0;
        bus.cpu_address    = '0;
        bus.cpu_writedata  = '0;
        @(posedge clk);
        #1;

        // Reset held for three cycles while both ports request
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 15'h0100, 1'b1, 1'b0, 4'hF, 15'h0200, 32'h0);
            checkOutput("rst_vid_grant", obs_vgnt, 1'b0);
            checkOutput("rst_cpu_grant", obs_cgnt, 1'b0);
            checkOutput("rst_vid_valid", obs_vvalid, 1'b0);
            checkOutput("rst_cpu_valid", obs_cvalid, 1'b0);
            checkOutput("rst_chipselect", obs_cs, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 15'h0100, 1'b1, 1'b0, 4'hF, 15'h0200, 32'h0);
        checkOutput("rst_release_vid_grant", obs_vgnt, 1'b1);

        // CPU writes with byte lanes, then reads the merged word back
        applyStimulus(1'b1, 1'b0, 1'b0, 15'h0, 1'b0, 1'b1, 4'hF, 15'h0010, 32'hDEADBEEF);
        checkOutput("wr1_cpu_grant", obs_cgnt, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 15'h0, 1'b0, 1'b1, 4'h3, 15'h0010, 32'h0000AAAA);
        checkOutput("wr2_cpu_grant", obs_cgnt, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 15'h0, 1'b1, 1'b0, 4'h0, 15'h0010, 32'h0);
        checkOutput("rd_cpu_grant", obs_cgnt, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
        checkOutput("rd_cpu_valid", obs_cvalid, 1'b1);
        checkOutput("rd_cpu_data", obs_crdata, 32'hDEADAAAA);
        checkOutput("rd_vid_valid", obs_vvalid, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
        checkOutput("rd_cpu_valid_once", obs_cvalid, 1'b0);

        // Continuous contention: eight video grants, then one CPU grant
        for (int i = 0; i < 23; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 15'(16'h0300 + i), 1'b1, 1'b0, 4'hF, 15'h0020, 32'h0);
            checkOutput("cont_vid_grant", obs_vgnt, (i % 9) != 8);
            checkOutput("cont_cpu_grant", obs_cgnt, (i % 9) == 8);
            checkOutput("cont_vid_valid", obs_vvalid, (i > 0) && (((i - 1) % 9) != 8));
            checkOutput("cont_cpu_valid", obs_cvalid, (i > 0) && (((i - 1) % 9) == 8));
        end

        // Freeze for three cycles with five video wins already counted
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 15'h0400, 1'b1, 1'b0, 4'hF, 15'h0020, 32'h0);
            checkOutput("frz_vid_grant", obs_vgnt, 1'b0);
            checkOutput("frz_cpu_grant", obs_cgnt, 1'b0);
            checkOutput("frz_clken", obs_clken, 1'b0);
            checkOutput("frz_vid_valid", obs_vvalid, i == 0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 15'(16'h0400 + i), 1'b1, 1'b0, 4'hF, 15'h0020, 32'h0);
            checkOutput("post_frz_vid_grant", obs_vgnt, i < 3);
            checkOutput("post_frz_cpu_grant", obs_cgnt, i == 3);
        end

        // Reset in the middle of contention clears the video run
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 1'b1, 15'h0500, 1'b1, 1'b0, 4'hF, 15'h0021, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 15'h0500, 1'b1, 1'b0, 4'hF, 15'h0021, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 15'h0501, 1'b1, 1'b0, 4'hF, 15'h0021, 32'h0);
        checkOutput("midrst_vid_grant", obs_vgnt, 1'b0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 15'(16'h0502 + i), 1'b1, 1'b0, 4'hF, 15'h0021, 32'h0);
            if (i == 0) checkOutput("midrst_vid_valid", obs_vvalid, 1'b0);
            checkOutput("midrst_vid_grant_run", obs_vgnt, i < 8);
            checkOutput("midrst_cpu_grant_run", obs_cgnt, i == 8);
        end

        // Read and write together behave as a write
        applyStimulus(1'b1, 1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 15'h0, 1'b1, 1'b1, 4'hF, 15'h7FFF, 32'h12345678);
        checkOutput("rw_cpu_grant", obs_cgnt, 1'b1);
        checkOutput("rw_mem_write", obs_mwrite, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 15'h0, 1'b1, 1'b0, 4'h0, 15'h7FFF, 32'h0);
        checkOutput("rw_no_cpu_valid", obs_cvalid, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
        checkOutput("rw_readback_valid", obs_cvalid, 1'b1);
        checkOutput("rw_readback_data", obs_crdata, 32'h12345678);

        // Randomized traffic; requests are held until granted
        vr = 1'b0; cr = 1'b0; cw = 1'b0;
        va = '0; ca = '0; be = '0; wd = '0;
        for (int n = 0; n < 1500; n++) begin
            frz = ($urandom_range(0, 9) == 0);
            applyStimulus(1'b1, frz, vr, va, cr, cw, be, ca, wd);
            if (model_gv || !vr) begin
                vr = ($urandom_range(0, 3) != 0);
                va = 15'($urandom_range(0, 63));
            end
            if (model_gc || !(cr || cw)) begin
                kind = $urandom_range(0, 5);
                cr = (kind == 2) || (kind == 3) || (kind == 5);
                cw = (kind == 4) || (kind == 5);
                ca = 15'($urandom_range(0, 63));
                be = 4'($urandom_range(0, 15));
                wd = $urandom;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end
endmodule
